// File: rtl/lampFPU_pkg.sv
// Floating-point field widths shared by the lampFPU blocks (single precision).
package lampFPU_pkg;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 23;
endpackage

// File: rtl/sqrt_req_arbiter.sv
// Round-robin front end sharing one SQRT_Floating_Point unit between N_REQ requesters,
// with zero/negative operand bypass and a watchdog on the unit's result.
module sqrt_req_arbiter
  import lampFPU_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req_valid_i,
  input  logic [N_REQ-1:0]                     req_inv_i,
  input  logic [N_REQ-1:0]                     req_s_i,
  input  logic [N_REQ*LAMP_FLOAT_E_DW-1:0]     req_e_i,
  input  logic [N_REQ*(LAMP_FLOAT_F_DW+1)-1:0] req_m_i,
  output logic [N_REQ-1:0]                     req_ready_o,
  output logic [N_REQ-1:0]                     rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic                                 rsp_s_o,
  output logic [LAMP_FLOAT_E_DW-1:0]           rsp_e_o,
  output logic [LAMP_FLOAT_F_DW:0]             rsp_m_o,
  output logic                                 rsp_err_o,
  output logic                                 busy_o,
  output logic                                 sq_do_sqrt_o,
  output logic                                 sq_do_inv_o,
  output logic                                 sq_s_o,
  output logic [LAMP_FLOAT_E_DW-1:0]           sq_e_o,
  output logic [LAMP_FLOAT_F_DW:0]             sq_m_o,
  input  logic                                 sq_valid_i,
  input  logic                                 sq_s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]           sq_e_i,
  input  logic [LAMP_FLOAT_F_DW:0]             sq_m_i
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int SC_W = ID_W + 1;
  localparam int E_DW = LAMP_FLOAT_E_DW;
  localparam int M_W  = LAMP_FLOAT_F_DW + 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, gnt_reg, gnt_idx;
  logic              gnt_found;
  logic [SC_W-1:0]   scan_idx;
  logic              inv_reg, op_s_reg;
  logic [E_DW-1:0]   op_e_reg;
  logic [M_W-1:0]    op_m_reg;
  logic              rsp_s_reg, rsp_err_reg;
  logic [E_DW-1:0]   rsp_e_reg;
  logic [M_W-1:0]    rsp_m_reg;
  logic [WD_W-1:0]   wd_reg;

  logic [E_DW-1:0]   req_e_arr [N_REQ];
  logic [M_W-1:0]    req_m_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_e_arr[gi] = req_e_i[gi*E_DW +: E_DW];
      assign req_m_arr[gi] = req_m_i[gi*M_W +: M_W];
    end
  endgenerate

  // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_reg} + SC_W'(i);
      if (scan_idx >= SC_W'(N_REQ)) scan_idx = scan_idx - SC_W'(N_REQ);
      if (!gnt_found && req_valid_i[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  logic            sel_s, sel_inv, sel_zero;
  logic [E_DW-1:0] sel_e;
  logic [M_W-1:0]  sel_m;

  assign sel_s    = req_s_i[gnt_idx];
  assign sel_inv  = req_inv_i[gnt_idx];
  assign sel_e    = req_e_arr[gnt_idx];
  assign sel_m    = req_m_arr[gnt_idx];
  assign sel_zero = (sel_m == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_found) state_next = (sel_zero || sel_s) ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (sq_valid_i || wd_reg == WD_LAST) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg  <= '0;
      gnt_reg     <= '0;
      inv_reg     <= 1'b0;
      op_s_reg    <= 1'b0;
      op_e_reg    <= '0;
      op_m_reg    <= '0;
      rsp_s_reg   <= 1'b0;
      rsp_e_reg   <= '0;
      rsp_m_reg   <= '0;
      rsp_err_reg <= 1'b0;
      wd_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: if (gnt_found) begin
          gnt_reg    <= gnt_idx;
          rr_ptr_reg <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : ID_W'(gnt_idx + ID_W'(1));
          inv_reg    <= sel_inv;
          op_s_reg   <= sel_s;
          op_e_reg   <= sel_e;
          op_m_reg   <= sel_m;
          // Bypass results are settled here; the unit path overwrites them in WAIT.
          rsp_s_reg  <= sel_zero && !sel_inv && sel_s;
          rsp_e_reg  <= '0;
          rsp_m_reg  <= '0;
          rsp_err_reg <= sel_zero ? sel_inv : sel_s;
        end
        ISSUE: wd_reg <= '0;
        WAIT: begin
          wd_reg <= wd_reg + WD_W'(1);
          if (sq_valid_i) begin
            rsp_s_reg   <= sq_s_i;
            rsp_e_reg   <= sq_e_i;
            rsp_m_reg   <= sq_m_i;
            rsp_err_reg <= 1'b0;
          end else if (wd_reg == WD_LAST) begin
            rsp_s_reg   <= 1'b0;
            rsp_e_reg   <= '0;
            rsp_m_reg   <= '0;
            rsp_err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The ready strobe is combinational from req_valid_i, so it is masked while reset is held.
  always_comb begin
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    sq_do_sqrt_o = 1'b0;
    sq_do_inv_o  = 1'b0;
    sq_s_o       = 1'b0;
    sq_e_o       = '0;
    sq_m_o       = '0;
    if (state_reg == IDLE && gnt_found && rst) req_ready_o[gnt_idx] = 1'b1;
    if (state_reg == RESP) rsp_valid_o[gnt_reg] = 1'b1;
    if (state_reg == ISSUE) begin
      sq_do_sqrt_o = !inv_reg;
      sq_do_inv_o  = inv_reg;
    end
    if (state_reg == ISSUE || state_reg == WAIT) begin
      sq_s_o = op_s_reg;
      sq_e_o = op_e_reg;
      sq_m_o = op_m_reg;
    end
  end

  assign busy_o    = (state_reg != IDLE);
  assign rsp_s_o   = rsp_s_reg;
  assign rsp_e_o   = rsp_e_reg;
  assign rsp_m_o   = rsp_m_reg;
  assign rsp_err_o = rsp_err_reg;

endmodule
